seq_1011_transmitter: RTL and testbench

//   Serial sequence transmitter that emits a fixed bit pattern (default 1011), MSB first, one bit per clock.

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_piso_shift.sv | 32 +++
 rtl/seq_1011_transmitter.sv | 133 +++++++++++++
 tb/tb_seq_1011_transmitter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 sequence transmitter and detectors.
// State encoding and default pattern constants.
package seq_pkg;

  localparam int SEQ_WIDTH = 4;
  localparam logic [3:0] PATTERN_1011 = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-load, serial-out shift register.
// MSB is presented first; zeros shift in from the LSB.
module seq_piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  // clear beats load beats shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
    end else if (clr) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/seq_1011_transmitter.sv
// Serial pattern transmitter: sends N frames of PATTERN,
// MSB first, with GAP zero bits between frames.
module seq_1011_transmitter
  import seq_pkg::*;
#(
  parameter int             WIDTH   = SEQ_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(PATTERN_1011),
  parameter int             GAP     = 2,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frames,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [CNT_W-1:0] frm_cnt;

  logic last_bit;
  logic last_frm;
  logic gap_end;
  logic sr_load;
  logic sr_shift;
  logic msb;

  assign last_bit = (bit_cnt == '0);
  assign last_frm = (frm_cnt == CNT_W'(1));
  assign gap_end  = (gap_cnt == '0);

  // shift register control follows the state transitions below
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    if (!abort) begin
      case (state)
        S_IDLE: sr_load = start && (frames != '0);
        S_SEND: begin
          sr_shift = 1'b1;
          sr_load  = last_bit && !last_frm && (GAP == 0);
        end
        S_GAP:  sr_load = gap_end;
        default: ;
      endcase
    end
  end

  seq_piso_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (PATTERN),
    .msb   (msb)
  );

  // run sequencing: frame and bit/gap counters with abort override
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      frm_cnt <= '0;
    end else if (abort) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      frm_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (frames != '0) begin
              state   <= S_SEND;
              bit_cnt <= BW'(WIDTH - 1);
              frm_cnt <= frames;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_SEND: begin
          if (last_bit) begin
            if (last_frm) begin
              state <= S_DONE;
            end else if (GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= GW'(GAP - 1);
              frm_cnt <= frm_cnt - CNT_W'(1);
            end else begin
              bit_cnt <= BW'(WIDTH - 1);
              frm_cnt <= frm_cnt - CNT_W'(1);
            end
          end else begin
            bit_cnt <= bit_cnt - BW'(1);
          end
        end
        S_GAP: begin
          if (gap_end) begin
            state   <= S_SEND;
            bit_cnt <= BW'(WIDTH - 1);
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode from registered state and shift MSB
  always_comb begin
    x       = (state == S_SEND) && msb;
    x_valid = (state == S_SEND) || (state == S_GAP);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
  end

endmodule

// File: tb/tb_seq_1011_transmitter.sv
// Self-checking bench: two transmitters (GAP=2, GAP=0)
// compared cycle by cycle against a frame-list model.
module tb_seq_1011_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] frames = '0;
  logic       abort = 1'b0;

  logic x0, xv0, busy0, done0;
  logic x1, xv1, busy1, done1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_1011_transmitter #(.GAP(2)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .start   (start0),
    .frames  (frames),
    .abort   (abort),
    .x       (x0),
    .x_valid (xv0),
    .busy    (busy0),
    .done    (done0)
  );

  seq_1011_transmitter #(.GAP(0)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .frames  (frames),
    .abort   (abort),
    .x       (x1),
    .x_valid (xv1),
    .busy    (busy1),
    .done    (done1)
  );

  // packed {x_valid, x, busy, done}
  function automatic logic [3:0] obs(input int which);
    if (which == 1) return {xv1, x1, busy1, done1};
    return {xv0, x0, busy0, done0};
  endfunction

  task automatic check(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 1) start1 = v;
    else start0 = v;
  endtask

  // expected serial stream: n frames of 1011, gap zeros between
  task automatic build(input int n, input int gap, output bit q[$]);
    logic [3:0] pat;
    pat = 4'b1011;
    q = {};
    for (int f = 0; f < n; f++) begin
      for (int b = 3; b >= 0; b--) q.push_back(pat[b]);
      if (f != n - 1)
        for (int g = 0; g < gap; g++) q.push_back(1'b0);
    end
  endtask

  // one run; abort_at / mid_start are cycle indices (-1 = never)
  task automatic run(input int which, input int n, input int abort_at,
                     input int mid_start, output int hits);
    bit q[$];
    bit seen[$];
    string tag;
    build(n, (which == 1) ? 0 : 2, q);
    hits = 0;
    tag = $sformatf("run%0d_n%0d", which, n);
    @(negedge clk);
    frames = 8'(n);
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
          check({tag, "_abort"}, obs(which), 4'b0000);
          @(posedge clk); #1;
        end
        return;
      end
      if (i == mid_start) begin
        frames = 8'(n + 3);
        set_start(which, 1'b1);
      end else begin
        set_start(which, 1'b0);
      end
      check(tag, obs(which), {1'b1, q[i], 1'b1, 1'b0});
      if (obs(which) ==? 4'b1?10) begin
        seen.push_back(obs(which) == 4'b1110);
        if (seen.size() >= 4 && seen[$-3] && !seen[$-2] && seen[$-1]
            && seen[$])
          hits++;
      end
      @(posedge clk); #1;
    end
    set_start(which, 1'b0);
    check({tag, "_done"}, obs(which), 4'b0011);
    @(posedge clk); #1;
    check({tag, "_idle"}, obs(which), 4'b0000);
  endtask

  initial begin
    int hits;
    int nf;

    // reset state
    #12;
    check("rst0", obs(0), 4'b0000);
    check("rst1", obs(1), 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle0", obs(0), 4'b0000);

    // reset asserted mid-SEND clears outputs without a clock
    @(negedge clk);
    frames = 8'd3;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", obs(0) & 4'b0010, 4'b0010);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", obs(0), 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst", obs(0), 4'b0000);

    // single frame
    run(0, 1, -1, -1, hits);
    check("hits1", 4'(hits), 4'd1);

    // three frames with gaps, one 1011 per frame
    run(0, 3, -1, -1, hits);
    check("hits3", 4'(hits), 4'd3);

    // back-to-back, start mid-run ignored
    run(1, 2, -1, 3, hits);
    check("hits2", 4'(hits), 4'd2);

    // frames = 0: immediate done
    @(negedge clk);
    frames = 8'd0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("zero_done", obs(0), 4'b0011);
    @(posedge clk); #1;
    check("zero_idle", obs(0), 4'b0000);

    // abort in cycle 3 of a 5-frame run
    run(0, 5, 2, -1, hits);
    run(1, 5, 2, -1, hits);

    // abort and start together in IDLE
    @(negedge clk);
    frames = 8'd2;
    start0 = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("abort_start", obs(0), 4'b0000);
      @(posedge clk); #1;
    end

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      nf = int'($urandom_range(1, 6));
      run(r % 2, nf, -1, int'($urandom_range(0, 8)), hits);
      check("rand_hits", 4'(hits), 4'(nf));
    end

    // full-scale frame count
    run(0, 255, -1, -1, hits);
    check("hits255", 8'(hits) == 8'd255 ? 4'd1 : 4'd0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
